// File: rtl/digit_serial_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package digit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..ndig-1, never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_slice_adder.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module digit_slice_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract through one shared DIGIT-bit slice,
// with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | ready for operands (IN_READY=1)
//   RUN   | one digit per cycle through the slice, LSB digit first
//   DONE  | result held with OUT_VALID=1 until OUT_READY
module digit_serial_addsub
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
  logic             carry, cout_r, ovf_r;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] s;
  logic             co, c_msb;
  logic             accept, last;

  assign accept = (state == IDLE) && IN_VALID;
  assign last   = (state == RUN) && (cnt == CW'(NDIG - 1));

  digit_slice_adder #(.DIGIT(DIGIT)) u_slice (
    .a     (op_a[DIGIT-1:0]),
    .b     (op_b[DIGIT-1:0]),
    .ci    (carry),
    .s     (s),
    .co    (co),
    .c_msb (c_msb)
  );

  // New digits enter at the top so the result is LSB-aligned after NDIG shifts.
  generate
    if (NDIG == 1) begin : g_single
      assign res_nxt = s;
    end else begin : g_multi
      assign res_nxt = {s, res[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      op_a  <= A;
      op_b  <= SUB ? ~B : B;
      carry <= CIN ^ SUB;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      res   <= res_nxt;
      carry <= co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout_r <= co;
        ovf_r  <= co ^ c_msb;
      end
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign SUM       = res;
  assign COUT      = cout_r;
  assign OVF       = ovf_r;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench: four parameterisations of digit_serial_addsub share the stimulus.
module tb_digit_serial_addsub;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        CIN = 1'b0;
  logic        SUB = 1'b0;

  // index 0: (16,4)  1: (16,1)  2: (16,16)  3: (8,2)
  logic [3:0]  rdy, vld, co, ov;
  logic [15:0] sm0, sm1, sm2;
  logic [7:0]  sm3;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy[0]), .A(A), .B(B),
    .CIN(CIN), .SUB(SUB), .OUT_VALID(vld[0]), .OUT_READY(OUT_READY),
    .SUM(sm0), .COUT(co[0]), .OVF(ov[0]));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) dut_bit (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy[1]), .A(A), .B(B),
    .CIN(CIN), .SUB(SUB), .OUT_VALID(vld[1]), .OUT_READY(OUT_READY),
    .SUM(sm1), .COUT(co[1]), .OVF(ov[1]));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut_wide (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy[2]), .A(A), .B(B),
    .CIN(CIN), .SUB(SUB), .OUT_VALID(vld[2]), .OUT_READY(OUT_READY),
    .SUM(sm2), .COUT(co[2]), .OVF(ov[2]));

  digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) dut_byte (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy[3]), .A(A[7:0]), .B(B[7:0]),
    .CIN(CIN), .SUB(SUB), .OUT_VALID(vld[3]), .OUT_READY(OUT_READY),
    .SUM(sm3), .COUT(co[3]), .OVF(ov[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on all four instances; OUT_READY stays low and IN_VALID stays
  // high with different operands until every instance has been in DONE a while.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input logic [7:0] es8, input logic ec8, input logic eo8);
    int          lat [4];
    logic        hold_ok, busy_ok;
    logic [15:0] held;
    for (int d = 0; d < 4; d++) lat[d] = -1;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    held    = '0;
    A = a; B = b; CIN = cin; SUB = sub; IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    A = ~a; B = ~b + 16'h0101; CIN = ~cin; SUB = ~sub;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      if (rdy[0]) busy_ok = 1'b0;
      @(posedge CLK); #1;
      for (int d = 1; d < 4; d++) if (lat[d] < 0 && vld[d]) lat[d] = cyc;
      if (lat[0] < 0 && vld[0]) begin
        lat[0] = cyc;
        held   = sm0;
      end else if (lat[0] > 0 && (sm0 !== held || !vld[0])) begin
        hold_ok = 1'b0;
      end
    end
    IN_VALID = 1'b0;
    chk({tag, "/lat_d4"},  lat[0], 4);
    chk({tag, "/lat_d1"},  lat[1], 16);
    chk({tag, "/lat_d16"}, lat[2], 1);
    chk({tag, "/lat_w8"},  lat[3], 4);
    chk({tag, "/busy"},    {busy_ok, rdy}, 5'b1_0000);
    chk({tag, "/hold"},    hold_ok, 1'b1);
    chk({tag, "/sum_d4"},  sm0, es);
    chk({tag, "/sum_d1"},  sm1, es);
    chk({tag, "/sum_d16"}, sm2, es);
    chk({tag, "/sum_w8"},  sm3, es8);
    chk({tag, "/cout"},    co, {ec8, ec, ec, ec});
    chk({tag, "/ovf"},     ov, {eo8, eo, eo, eo});
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk({tag, "/post_rdy"}, rdy, 4'hF);
    chk({tag, "/post_vld"}, vld, 4'h0);
    chk({tag, "/sum_kept"}, sm0, es);
  endtask

  initial begin
    logic stray;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst/rdy",  rdy, 4'hF);
    chk("rst/vld",  vld, 4'h0);
    chk("rst/sum",  {sm0, sm1, sm2, sm3}, 56'h0);
    chk("rst/flag", {co, ov}, 8'h00);
    RST = 1'b0;

    run_op("add_basic", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 8'h55, 0, 0);
    run_op("add_cout",  16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 8'h00, 1, 0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 8'h00, 1, 0);
    run_op("sub_borr",  16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 8'hFE, 0, 0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 8'hFF, 0, 0);
    run_op("sub_bin",   16'h0005, 16'h0003, 1, 1, 16'h0001, 1, 0, 8'h01, 1, 0);
    run_op("add_cin",   16'h00FF, 16'h0001, 1, 0, 16'h0101, 0, 0, 8'h01, 1, 0);
    run_op("sub_mix",   16'h807F, 16'h0080, 0, 1, 16'h7FFF, 1, 1, 8'hFF, 0, 1);
    run_op("add_alt",   16'hA5A5, 16'h5A5A, 1, 0, 16'h0000, 1, 0, 8'h00, 1, 0);
    run_op("add_pos",   16'h4000, 16'h4000, 0, 0, 16'h8000, 0, 1, 8'h00, 0, 0);
    run_op("sub_zero",  16'h0000, 16'h0000, 1, 1, 16'hFFFF, 0, 0, 8'hFF, 0, 0);
    run_op("add_neg",   16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 8'h00, 0, 0);

    // Abort mid-run; OUT_READY high during RUN must not disturb the (16,4) instance.
    A = 16'h1234; B = 16'h4321; CIN = 1'b0; SUB = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("early_ready", {rdy[0], vld[0]}, 2'b00);
    RST = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort/rdy",  rdy[0], 1'b1);
    chk("abort/vld",  vld[0], 1'b0);
    chk("abort/sum",  sm0, 16'h0000);
    chk("abort/flag", {co[0], ov[0]}, 2'b00);
    stray = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (vld[0] || !rdy[0]) stray = 1'b1;
    end
    chk("abort/quiet", stray, 1'b0);

    run_op("after_rst", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 8'h55, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
